// File: rtl/split_bus_arbiter_pkg.sv
// split_bus_arbiter_pkg: master/state encodings and slave-range helpers shared by the arbiter and bridges
package split_bus_arbiter_pkg;
  typedef enum logic {M1 = 1'b0, M2 = 1'b1} master_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam int NUM_SLAVES_DEF = 3;
  function automatic logic slave_ok(input int sel, input int num_slaves);
    return sel < num_slaves;
  endfunction
endpackage

// File: rtl/hold_timer.sv
// hold_timer: clearable cycle counter flagging terminal count MAX_COUNT-1
module hold_timer #(
  parameter int MAX_COUNT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(MAX_COUNT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc_o = cnt_q == W'(MAX_COUNT - 1);
endmodule

// File: rtl/split_bus_arbiter.sv
// split_bus_arbiter: two-master round-robin bus arbiter with one parked split and a hold timeout
module split_bus_arbiter import split_bus_arbiter_pkg::*; #(
  parameter int SLAVE_LEN  = 2,
  parameter int NUM_SLAVES = NUM_SLAVES_DEF,
  parameter int MAX_COUNT  = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_request,
  input  logic                  m2_request,
  input  logic [SLAVE_LEN-1:0]  m1_slave_sel,
  input  logic [SLAVE_LEN-1:0]  m2_slave_sel,
  input  logic                  trans_done,
  input  logic [NUM_SLAVES-1:0] s_split_en,
  input  logic [NUM_SLAVES-1:0] s_split_ready,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  m1_split,
  output logic                  m2_split,
  output logic [SLAVE_LEN-1:0]  sel_slave,
  output logic                  bus_busy,
  output logic                  arbiter_busy,
  output logic                  timeout
);
  state_e state_q, state_d;
  master_e last_q, last_d;
  logic g1_q, g1_d, g2_q, g2_d, sp1_q, sp1_d, sp2_q, sp2_d, pend_q, pend_d;
  logic bus_q, bus_d, abusy_q, abusy_d, tmo_q, tmo_d;
  logic [SLAVE_LEN-1:0] sel_q, sel_d, park_s_q, park_s_d;
  logic ok1, ok2, park, tc;
  master_e owner;
  hold_timer #(.MAX_COUNT(MAX_COUNT)) u_timer (
    .clk  (clk),
    .rst  (reset),
    .clr_i(state_q == IDLE),
    .en_i (state_q == BUSY),
    .tc_o (tc)
  );
  assign park  = sp1_q | sp2_q;
  assign owner = g1_q ? M1 : M2;
  assign ok1   = m1_request && slave_ok(int'(m1_slave_sel), NUM_SLAVES) && !sp1_q;
  assign ok2   = m2_request && slave_ok(int'(m2_slave_sel), NUM_SLAVES) && !sp2_q;
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    g1_d     = g1_q;
    g2_d     = g2_q;
    sp1_d    = sp1_q;
    sp2_d    = sp2_q;
    pend_d   = pend_q;
    sel_d    = sel_q;
    park_s_d = park_s_q;
    tmo_d    = 1'b0;
    if (park && s_split_ready[park_s_q]) pend_d = 1'b1;
    if (state_q == IDLE) begin
      if (pend_q) begin
        g1_d    = sp1_q;
        g2_d    = sp2_q;
        sel_d   = park_s_q;
        sp1_d   = 1'b0;
        sp2_d   = 1'b0;
        pend_d  = 1'b0;
        state_d = BUSY;
      end else if (ok1 && (!ok2 || last_q == M2)) begin
        g1_d    = 1'b1;
        sel_d   = m1_slave_sel;
        state_d = BUSY;
      end else if (ok2) begin
        g2_d    = 1'b1;
        sel_d   = m2_slave_sel;
        state_d = BUSY;
      end
    end else if (trans_done) begin
      {g1_d, g2_d} = 2'b00;
      last_d  = owner;
      state_d = IDLE;
    end else if (s_split_en[sel_q] && !park) begin
      // the split slave may already be ready in the same cycle
      sp1_d    = g1_q;
      sp2_d    = g2_q;
      park_s_d = sel_q;
      pend_d   = s_split_ready[sel_q];
      {g1_d, g2_d} = 2'b00;
      state_d  = IDLE;
    end else if (tc) begin
      {g1_d, g2_d} = 2'b00;
      last_d  = owner;
      tmo_d   = 1'b1;
      state_d = IDLE;
    end
    bus_d   = g1_d | g2_d;
    abusy_d = bus_d | sp1_d | sp2_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= M2;
      {g1_q, g2_q, sp1_q, sp2_q, pend_q, bus_q, abusy_q, tmo_q} <= '0;
      sel_q    <= '0;
      park_s_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      {g1_q, g2_q, sp1_q, sp2_q, pend_q} <= {g1_d, g2_d, sp1_d, sp2_d, pend_d};
      {bus_q, abusy_q, tmo_q} <= {bus_d, abusy_d, tmo_d};
      sel_q    <= sel_d;
      park_s_q <= park_s_d;
    end
  end
  assign m1_grant     = g1_q;
  assign m2_grant     = g2_q;
  assign m1_split     = sp1_q;
  assign m2_split     = sp2_q;
  assign sel_slave    = sel_q;
  assign bus_busy     = bus_q;
  assign arbiter_busy = abusy_q;
  assign timeout      = tmo_q;
endmodule
